// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for reg_file_2r1w: write port, two enabled read ports, clear and written mask.
// The master drives requests; the slave (register file) returns registered read data and the mask.
interface reg_file_2r1w_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3,
  parameter int DEPTH = 8
) ();
  logic             clr;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             ra_en;
  logic [AW-1:0]    ra_addr;
  logic             rb_en;
  logic [AW-1:0]    rb_addr;
  logic [WIDTH-1:0] ra_data;
  logic [WIDTH-1:0] rb_data;
  logic [DEPTH-1:0] wr_mask;

  modport master (
    output clr, we, waddr, wdata, ra_en, ra_addr, rb_en, rb_addr,
    input  ra_data, rb_data, wr_mask
  );

  modport slave (
    input  clr, we, waddr, wdata, ra_en, ra_addr, rb_en, rb_addr,
    output ra_data, rb_data, wr_mask
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// DEPTH x WIDTH register file, one write port, two registered read ports with write-through bypass.
// Define ZERO_REG_EN to hardwire entry 0 to zero (writes to it ignored, its mask bit stays 0).
module reg_file_2r1w #(
  parameter int WIDTH = 16,
  parameter int AW    = 3,
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_file_2r1w_if.slave bus
);

`ifdef ZERO_REG_EN
  localparam bit ZERO_HARD = 1'b1;
`else
  localparam bit ZERO_HARD = 1'b0;
`endif

  logic [WIDTH-1:0] w_mem [DEPTH];
  logic [DEPTH-1:0] w_wr_hit;
  logic [DEPTH-1:0] w_wr_mask;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_ra_next;
  logic [WIDTH-1:0] w_rb_next;
  logic [WIDTH-1:0] r_ra_data;
  logic [WIDTH-1:0] r_rb_data;

  // A write to the hardwired zero entry is dropped entirely, which also suppresses its bypass.
  assign w_wr_ok = bus.we && !(ZERO_HARD && (bus.waddr == '0));

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] r_entry;
      logic             r_written;

      assign w_wr_hit[gi]  = w_wr_ok && (bus.waddr == AW'(gi));
      assign w_mem[gi]     = r_entry;
      assign w_wr_mask[gi] = r_written;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_entry   <= '0;
          r_written <= 1'b0;
        end else if (bus.clr) begin
          r_entry   <= '0;
          r_written <= 1'b0;
        end else if (w_wr_hit[gi]) begin
          r_entry   <= bus.wdata;
          r_written <= 1'b1;
        end
      end
    end
  endgenerate

  assign w_ra_next = (w_wr_ok && (bus.waddr == bus.ra_addr)) ? bus.wdata : w_mem[bus.ra_addr];
  assign w_rb_next = (w_wr_ok && (bus.waddr == bus.rb_addr)) ? bus.wdata : w_mem[bus.rb_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ra_data <= '0;
      r_rb_data <= '0;
    end else if (bus.clr) begin
      r_ra_data <= '0;
      r_rb_data <= '0;
    end else begin
      if (bus.ra_en) r_ra_data <= w_ra_next;
      if (bus.rb_en) r_rb_data <= w_rb_next;
    end
  end

  assign bus.ra_data = r_ra_data;
  assign bus.rb_data = r_rb_data;
  assign bus.wr_mask = w_wr_mask;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: array-level reference model checked every cycle
// plus hand-computed literal expectations from the directed test plan.
module tb_reg_file_2r1w;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  bit   cmp_on   = 0;

`ifdef ZERO_REG_EN
  localparam bit ZERO_HARD = 1'b1;
`else
  localparam bit ZERO_HARD = 1'b0;
`endif

  reg_file_2r1w_if #(.WIDTH(16), .AW(3), .DEPTH(8)) bus ();

  reg_file_2r1w #(.WIDTH(16), .AW(3), .DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: apply the write to the array first, then read the updated array,
  // which yields write-through behaviour without a separate bypass rule.
  logic [15:0] m_mem [8];
  logic [15:0] m_ra;
  logic [15:0] m_rb;
  logic [7:0]  m_mask;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || bus.clr) begin
        for (int i = 0; i < 8; i++) m_mem[i] = 16'h0;
        m_ra = 16'h0; m_rb = 16'h0; m_mask = 8'h0;
      end else begin
        if (bus.we && !(ZERO_HARD && bus.waddr == 3'd0)) begin
          m_mem[bus.waddr]  = bus.wdata;
          m_mask[bus.waddr] = 1'b1;
        end
        if (bus.ra_en) m_ra = m_mem[bus.ra_addr];
        if (bus.rb_en) m_rb = m_mem[bus.rb_addr];
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        check("model_ra", bus.ra_data, m_ra);
        check("model_rb", bus.rb_data, m_rb);
        check("model_mask", {8'h0, bus.wr_mask}, {8'h0, m_mask});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.clr = 0; bus.we = 0; bus.waddr = 0; bus.wdata = 0;
    bus.ra_en = 0; bus.ra_addr = 0; bus.rb_en = 0; bus.rb_addr = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    idle();
    bus.we = 1; bus.waddr = a; bus.wdata = d;
    tick();
  endtask

  task automatic rd(input logic [2:0] a, input logic [2:0] b);
    idle();
    bus.ra_en = 1; bus.ra_addr = a; bus.rb_en = 1; bus.rb_addr = b;
    tick();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick(); tick();
    check("reset_ra", bus.ra_data, 16'h0);
    check("reset_rb", bus.rb_data, 16'h0);
    check("reset_mask", {8'h0, bus.wr_mask}, 16'h0);
    rst_n = 1'b1;
    cmp_on = 1;

    // 1: sweep reads after reset
    for (int a = 0; a < 8; a++) begin
      idle(); bus.ra_en = 1; bus.ra_addr = 3'(a);
      tick();
      check($sformatf("sweep_ra_%0d", a), bus.ra_data, 16'h0);
    end
    check("sweep_mask", {8'h0, bus.wr_mask}, 16'h0);

    // 2: write then read on both ports
    wr(3'd3, 16'hA5A5);
    rd(3'd3, 3'd3);
    check("wr_rd_ra", bus.ra_data, 16'hA5A5);
    check("wr_rd_rb", bus.rb_data, 16'hA5A5);
    check("wr_rd_mask", {8'h0, bus.wr_mask}, 16'h0008);

    // 3: bypass on A, B disabled holds
    wr(3'd5, 16'h1111);
    idle();
    bus.we = 1; bus.waddr = 3'd5; bus.wdata = 16'h2222; bus.ra_en = 1; bus.ra_addr = 3'd5;
    tick();
    check("bypass_ra", bus.ra_data, 16'h2222);
    check("bypass_rb_hold", bus.rb_data, 16'hA5A5);
    check("bypass_mask", {8'h0, bus.wr_mask}, 16'h0028);

    // both ports bypass the same write
    idle();
    bus.we = 1; bus.waddr = 3'd6; bus.wdata = 16'h3333;
    bus.ra_en = 1; bus.ra_addr = 3'd6; bus.rb_en = 1; bus.rb_addr = 3'd6;
    tick();
    check("bypass2_ra", bus.ra_data, 16'h3333);
    check("bypass2_rb", bus.rb_data, 16'h3333);
    rd(3'd5, 3'd3);
    check("after_bypass_ra", bus.ra_data, 16'h2222);
    check("after_bypass_rb", bus.rb_data, 16'hA5A5);

    // fill every entry, read pairs back
    for (int a = 0; a < 8; a++) wr(3'(a), 16'(a * 16'h1010 + 1));
    for (int a = 0; a < 8; a++) rd(3'(a), 3'(7 - a));
    check("fill_ra_7", bus.ra_data, 16'h7071);
    check("fill_rb_0", bus.rb_data, ZERO_HARD ? 16'h0 : 16'h0001);

    // 4: clear priority over write and reads
    wr(3'd1, 16'h0101);
    wr(3'd2, 16'h0202);
    idle();
    bus.clr = 1; bus.we = 1; bus.waddr = 3'd4; bus.wdata = 16'hFFFF;
    bus.ra_en = 1; bus.ra_addr = 3'd1; bus.rb_en = 1; bus.rb_addr = 3'd2;
    tick();
    check("clr_ra", bus.ra_data, 16'h0);
    check("clr_rb", bus.rb_data, 16'h0);
    check("clr_mask", {8'h0, bus.wr_mask}, 16'h0);
    rd(3'd4, 3'd1);
    check("clr_rd4", bus.ra_data, 16'h0);
    check("clr_rd1", bus.rb_data, 16'h0);

    // 5: async reset between edges while a write is pending
    wr(3'd7, 16'h7777);
    rd(3'd7, 3'd7);
    check("pre_rst_ra", bus.ra_data, 16'h7777);
    idle();
    bus.we = 1; bus.waddr = 3'd2; bus.wdata = 16'h2222;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_ra", bus.ra_data, 16'h0);
    check("async_rb", bus.rb_data, 16'h0);
    check("async_mask", {8'h0, bus.wr_mask}, 16'h0);
    tick();
    idle();
    rst_n = 1'b1;
    rd(3'd2, 3'd7);
    check("post_rst_rd2", bus.ra_data, 16'h0);
    check("post_rst_rd7", bus.rb_data, 16'h0);

    // 6: write to entry 0 with same-cycle read
    idle();
    bus.we = 1; bus.waddr = 3'd0; bus.wdata = 16'hBEEF; bus.ra_en = 1; bus.ra_addr = 3'd0;
    tick();
    check("zero_ra", bus.ra_data, ZERO_HARD ? 16'h0 : 16'hBEEF);
    check("zero_mask0", {15'h0, bus.wr_mask[0]}, ZERO_HARD ? 16'h0 : 16'h1);
    rd(3'd0, 3'd0);
    check("zero_rd_rb", bus.rb_data, ZERO_HARD ? 16'h0 : 16'hBEEF);

    // rewrite keeps mask bit, disabled ports hold
    wr(3'd3, 16'h0033);
    wr(3'd3, 16'h0034);
    idle();
    tick();
    check("rewrite_mask", {8'h0, bus.wr_mask}, ZERO_HARD ? 16'h0008 : 16'h0009);
    check("hold_ra", bus.ra_data, ZERO_HARD ? 16'h0 : 16'hBEEF);
    rd(3'd3, 3'd3);
    check("rewrite_rd", bus.ra_data, 16'h0034);

    tick();
    cmp_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
